// File: rtl/data_mem_pkg.sv
// Shared core definitions used by the data memory and its bench.
//   Xlen            : datapath width in bits
//   XBytes          : byte lanes per word
//   DmemStateBits   : width of the data-memory FSM state
//   dmem_state_e    : data-memory FSM states (Idle, Busy, Respond)
package core_pkg;
  localparam int Xlen          = 32;
  localparam int XBytes        = Xlen / 8;
  localparam int DmemStateBits = 2;

  typedef enum logic [DmemStateBits-1:0] {
    DMEM_IDLE    = 2'd0,
    DMEM_BUSY    = 2'd1,
    DMEM_RESPOND = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/data_mem_if.sv
// Data-memory request/response handshake between the load/store unit
// (master) and the data memory (slave).
//   mem_valid_i / mem_ready_o : request handshake
//   mem_addr_i, mem_wdata_i, mem_wmask_i : request fields (wmask==0 -> read)
//   mem_rdata_o, mem_rvalid_o : one-cycle completion pulse with read data
interface data_mem_if;
  import core_pkg::*;

  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [Xlen-1:0]   mem_addr_i;
  logic [Xlen-1:0]   mem_wdata_i;
  logic [XBytes-1:0] mem_wmask_i;
  logic [Xlen-1:0]   mem_rdata_o;
  logic              mem_rvalid_o;

  modport master (
    output mem_valid_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
    input  mem_ready_o, mem_rdata_o, mem_rvalid_o
  );

  modport slave (
    input  mem_valid_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
    output mem_ready_o, mem_rdata_o, mem_rvalid_o
  );
endinterface

// File: rtl/data_mem_byte_ram.sv
// byte_ram: synchronous word array split into byte lanes.
//   clk_i, rst_ni : clock, synchronous active-low reset (read register only)
//   we_i, wmask_i, waddr_i, wdata_i : per-byte masked write
//   rd_en_i, raddr_i : read strobe and index
//   rdata_o : registered read data; loads the word when rd_en_i, else 0
// Array contents are never reset.
module byte_ram #(
  parameter int Words = 1024,
  parameter int Width = 32,
  localparam int Lanes = Width / 8,
  localparam int AddrW = $clog2(Words)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Lanes-1:0] wmask_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);
  for (genvar k = 0; k < Lanes; k++) begin : g_lane
    logic [7:0] mem_q [Words];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i && wmask_i[k]) mem_q[waddr_i] <= wdata_i[8*k +: 8];
    end

    // Read register returns to zero whenever no read is strobed, so the
    // output is only non-zero in the cycle after a read.
    always_ff @(posedge clk_i) begin
      if (!rst_ni)      rd_q <= '0;
      else if (rd_en_i) rd_q <= mem_q[raddr_i];
      else              rd_q <= '0;
    end

    assign rdata_o[8*k +: 8] = rd_q;
  end
endmodule

// File: rtl/data_mem.sv
// data_mem: responder end of the core's data-memory handshake.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   mem    : data_mem_if slave (valid/ready request, rvalid/rdata response)
// One request at a time: Idle (optional ready stall) -> Busy (Latency
// cycles, skipped when Latency==0) -> Respond (one-cycle rvalid) -> Idle.
// Writes commit at the acceptance edge; reads sample the array on the edge
// entering Respond.
module data_mem
  import core_pkg::*;
#(
  parameter int DepthWords = 1024,
  parameter int ReadyDelay = 0,
  parameter int Latency    = 0
) (
  input logic       clk_i,
  input logic       rst_ni,
  data_mem_if.slave mem
);
  localparam int AddrW = $clog2(DepthWords);

  dmem_state_e      state_q;
  logic [3:0]       stall_cnt_q;
  logic [3:0]       lat_cnt_q;
  logic [AddrW-1:0] idx_q;
  logic             is_wr_q;
  logic             rvalid_q;

  logic [AddrW-1:0] idx_live;
  logic             is_wr_live;
  logic             accept;
  logic             busy_done;
  logic             rd_en;
  logic [AddrW-1:0] raddr;
  logic             unused_addr;

  // Upper address bits alias; the byte offset is ignored.
  assign idx_live    = mem.mem_addr_i[AddrW+1:2];
  assign unused_addr = ^{mem.mem_addr_i[1:0], mem.mem_addr_i[Xlen-1:AddrW+2]};
  assign is_wr_live  = |mem.mem_wmask_i;

  assign mem.mem_ready_o = rst_ni && (state_q == DMEM_IDLE)
                           && (stall_cnt_q == 4'(ReadyDelay));
  assign accept    = mem.mem_valid_i && mem.mem_ready_o;
  assign busy_done = (state_q == DMEM_BUSY) && (lat_cnt_q == 4'(Latency));

  // Strobe the RAM read on the edge that enters Respond, so the registered
  // read data lines up with the rvalid pulse.
  assign rd_en = rst_ni &&
                 (((state_q == DMEM_IDLE) && accept && (Latency == 0) && !is_wr_live) ||
                  (busy_done && !is_wr_q));
  assign raddr = (state_q == DMEM_IDLE) ? idx_live : idx_q;

  byte_ram #(
    .Words (DepthWords),
    .Width (Xlen)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (accept && is_wr_live),
    .wmask_i (mem.mem_wmask_i),
    .waddr_i (idx_live),
    .wdata_i (mem.mem_wdata_i),
    .rd_en_i (rd_en),
    .raddr_i (raddr),
    .rdata_o (mem.mem_rdata_o)
  );

  assign mem.mem_rvalid_o = rvalid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= DMEM_IDLE;
      stall_cnt_q <= '0;
      lat_cnt_q   <= '0;
      idx_q       <= '0;
      is_wr_q     <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          rvalid_q <= 1'b0;
          if (accept) begin
            stall_cnt_q <= '0;
            idx_q       <= idx_live;
            is_wr_q     <= is_wr_live;
            if (Latency == 0) begin
              state_q  <= DMEM_RESPOND;
              rvalid_q <= 1'b1;
            end else begin
              state_q   <= DMEM_BUSY;
              lat_cnt_q <= 4'd1;
            end
          end else if (!mem.mem_valid_i) begin
            stall_cnt_q <= '0;
          end else if (stall_cnt_q != 4'(ReadyDelay)) begin
            stall_cnt_q <= stall_cnt_q + 4'd1;
          end
        end
        DMEM_BUSY: begin
          if (busy_done) begin
            state_q   <= DMEM_RESPOND;
            rvalid_q  <= 1'b1;
            lat_cnt_q <= '0;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        DMEM_RESPOND: begin
          rvalid_q <= 1'b0;
          state_q  <= DMEM_IDLE;
        end
        default: begin
          rvalid_q <= 1'b0;
          state_q  <= DMEM_IDLE;
        end
      endcase
    end
  end
endmodule
